// File: rtl/load_store_unit.sv
// Load/store unit backed by a word-organised little-endian data array.
// A single outstanding request is handled at a time. An optional wait-state
// counter delays the response. Misaligned, out-of-range and illegal accesses
// complete with resp_error and never modify memory.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no request in flight, ready to accept
// WAIT  | request latched, down-counter burning wait states, not ready
// RESP  | one-cycle response strobe; a new request may be accepted here
module load_store_unit #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic [ADDR_WIDTH-2:0] DEPTH_LIM = (ADDR_WIDTH-1)'(DEPTH_WORDS);
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    logic [31:0] memory [0:DEPTH_WORDS-1];

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  ready_en_q;
    logic                  lat_write_q;
    logic [2:0]            lat_funct3_q;
    logic [ADDR_WIDTH-1:0] lat_addr_q;
    logic [31:0]           lat_wdata_q;
    logic [31:0]           rdata_q, rdata_d;
    logic                  error_q, error_d;

    logic                  accept;
    logic                  enter_resp;
    logic                  op_write;
    logic [2:0]            op_funct3;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [31:0]           op_wdata;
    logic [IDX_W-1:0]      op_idx;
    logic [31:0]           rd_word;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_val;
    logic [3:0]            st_be;
    logic [31:0]           st_data;
    logic                  acc_err;
    logic                  mem_we;

    // ready is held off until the first edge after reset release
    assign req_ready  = ready_en_q && (state_q != WAIT);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

    // Next-state and wait-state counter control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (NO_WAIT) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In WAIT the latched request executes; otherwise the request on the
    // inputs executes in the same edge it is accepted (zero wait states).
    always_comb begin
        op_write  = (state_q == WAIT) ? lat_write_q  : req_write;
        op_funct3 = (state_q == WAIT) ? lat_funct3_q : req_funct3;
        op_addr   = (state_q == WAIT) ? lat_addr_q   : req_addr;
        op_wdata  = (state_q == WAIT) ? lat_wdata_q  : req_wdata;
        op_idx    = op_addr[IDX_W+1:2];
    end

    // Access legality, load extraction and store byte-lane generation
    always_comb begin
        acc_err = 1'b0;
        if (op_write)
            acc_err = op_funct3[2] || (op_funct3[1:0] == 2'b11);
        else
            acc_err = (op_funct3 == 3'b011) || (op_funct3[2:1] == 2'b11);
        if ((op_funct3[1:0] == 2'b01) && op_addr[0])
            acc_err = 1'b1;
        if ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00))
            acc_err = 1'b1;
        if ({1'b0, op_addr[ADDR_WIDTH-1:2]} >= DEPTH_LIM)
            acc_err = 1'b1;

        rd_word = memory[op_idx];
        ld_byte = rd_word[{op_addr[1:0], 3'b000} +: 8];
        ld_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (op_funct3)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_val = rd_word;
            3'b100:  ld_val = {24'd0, ld_byte};
            3'b101:  ld_val = {16'd0, ld_half};
            default: ld_val = 32'd0;
        endcase

        case (op_funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << op_addr[1:0];
                st_data = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = op_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{op_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = op_wdata;
            end
        endcase

        mem_we  = enter_resp && op_write && !acc_err;
        rdata_d = 32'd0;
        error_d = 1'b0;
        if (enter_resp) begin
            error_d = acc_err;
            if (!acc_err && !op_write)
                rdata_d = ld_val;
        end
    end

    // Control state, request latch and registered response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            ready_en_q   <= 1'b0;
            lat_write_q  <= 1'b0;
            lat_funct3_q <= 3'd0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= 32'd0;
            rdata_q      <= 32'd0;
            error_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
            if (accept) begin
                lat_write_q  <= req_write;
                lat_funct3_q <= req_funct3;
                lat_addr_q   <= req_addr;
                lat_wdata_q  <= req_wdata;
            end
        end
    end

    // Data array: byte-enabled write on the edge entering RESP, never reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i])
                    memory[op_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: three instances with 0, 3 and 2 wait
// states. Drivers push expected responses; a negedge monitor pops and compares.
module tb_load_store_unit;

    localparam int DW = 64;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rst2_n;
    logic        rv  [3];
    logic        rw  [3];
    logic [2:0]  rf3 [3];
    logic [31:0] ra  [3];
    logic [31:0] rwd [3];
    logic        rr  [3];
    logic        pv  [3];
    logic [31:0] pd  [3];
    logic        pe  [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.DEPTH_WORDS(DW), .WAIT_STATES(0), .ADDR_WIDTH(32)) dut0 (
        .clk(clk), .reset(rst_n), .req_valid(rv[0]), .req_ready(rr[0]),
        .req_write(rw[0]), .req_funct3(rf3[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
        .resp_valid(pv[0]), .resp_rdata(pd[0]), .resp_error(pe[0])
    );

    load_store_unit #(.DEPTH_WORDS(DW), .WAIT_STATES(3), .ADDR_WIDTH(32)) dut3 (
        .clk(clk), .reset(rst_n), .req_valid(rv[1]), .req_ready(rr[1]),
        .req_write(rw[1]), .req_funct3(rf3[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
        .resp_valid(pv[1]), .resp_rdata(pd[1]), .resp_error(pe[1])
    );

    load_store_unit #(.DEPTH_WORDS(DW), .WAIT_STATES(2), .ADDR_WIDTH(32)) dut2 (
        .clk(clk), .reset(rst2_n), .req_valid(rv[2]), .req_ready(rr[2]),
        .req_write(rw[2]), .req_funct3(rf3[2]), .req_addr(ra[2]), .req_wdata(rwd[2]),
        .resp_valid(pv[2]), .resp_rdata(pd[2]), .resp_error(pe[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [31:0] ed, input logic ee);
        exp_t x;
        x.d = ed;
        x.e = ee;
        case (d)
            0:       q0.push_back(x);
            1:       q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    // Present a request at a negedge, wait (bounded) for ready, push the
    // expected response and return just after the accepting edge.
    task automatic issue(input int d, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ee);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        rv[d] = 1'b1; rw[d] = w; rf3[d] = f3; ra[d] = a; rwd[d] = wd;
        for (int n = 0; n < 100; n++) begin
            if (rr[d] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout dut%0d actual=not_ready required=ready", d);
            rv[d] = 1'b0;
        end else begin
            push(d, ed, ee);
            @(posedge clk);
        end
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        rv[d] = 1'b0;
    endtask

    // Monitor: every response pops one expectation; outside responses the
    // data/error outputs must be zero.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int d = 0; d < 3; d++) begin
            if (pv[d] === 1'b1) begin
                have = 1'b0;
                e    = '0;
                case (d)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                endcase
                if (!have) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp dut%0d actual=resp_valid required=none", d);
                end else begin
                    chk($sformatf("resp_rdata dut%0d", d), pd[d], e.d);
                    chk($sformatf("resp_error dut%0d", d), {31'd0, pe[d]}, {31'd0, e.e});
                end
            end else begin
                chk($sformatf("idle_rdata dut%0d", d), pd[d], 32'd0);
                chk($sformatf("idle_error dut%0d", d), {31'd0, pe[d]}, 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rv[d] = 1'b0; rw[d] = 1'b0; rf3[d] = 3'd0; ra[d] = 32'd0; rwd[d] = 32'd0;
        end
        rst_n  = 1'b0;
        rst2_n = 1'b0;

        // reset state
        #12;
        chk("rst_ready dut0", {31'd0, rr[0]}, 32'd0);
        chk("rst_ready dut3", {31'd0, rr[1]}, 32'd0);
        chk("rst_valid dut0", {31'd0, pv[0]}, 32'd0);
        chk("rst_rdata dut0", pd[0], 32'd0);
        chk("rst_error dut0", {31'd0, pe[0]}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        #1;
        chk("ready_before_edge dut0", {31'd0, rr[0]}, 32'd0);
        @(negedge clk);
        chk("ready_after_edge dut0", {31'd0, rr[0]}, 32'd1);
        chk("ready_after_edge dut2", {31'd0, rr[2]}, 32'd1);

        // ---- zero wait states: preload, sub-word loads/stores ----
        issue(0, 1, 3'b010, 32'd0,   32'h8081_7F01, 32'h0,          1'b0);
        issue(0, 1, 3'b010, 32'd4,   32'h0000_0000, 32'h0,          1'b0);
        issue(0, 0, 3'b000, 32'd1,   32'h0,         32'h0000_007F, 1'b0);
        issue(0, 0, 3'b000, 32'd3,   32'h0,         32'hFFFF_FF80, 1'b0);
        issue(0, 0, 3'b100, 32'd3,   32'h0,         32'h0000_0080, 1'b0);
        issue(0, 0, 3'b000, 32'd2,   32'h0,         32'hFFFF_FF81, 1'b0);
        issue(0, 0, 3'b001, 32'd0,   32'h0,         32'h0000_7F01, 1'b0);
        issue(0, 0, 3'b001, 32'd2,   32'h0,         32'hFFFF_8081, 1'b0);
        idle(0);
        issue(0, 1, 3'b001, 32'd6,   32'h1234_ABCD, 32'h0,          1'b0);
        idle(0);
        issue(0, 0, 3'b001, 32'd6,   32'h0,         32'hFFFF_ABCD, 1'b0);
        issue(0, 0, 3'b101, 32'd6,   32'h0,         32'h0000_ABCD, 1'b0);
        issue(0, 0, 3'b010, 32'd4,   32'h0,         32'hABCD_0000, 1'b0);
        issue(0, 1, 3'b000, 32'd5,   32'h0000_0055, 32'h0,          1'b0);
        issue(0, 0, 3'b010, 32'd4,   32'h0,         32'hABCD_5500, 1'b0);
        idle(0);

        // ---- rejected accesses ----
        issue(0, 1, 3'b010, 32'd2,      32'hFFFF_FFFF, 32'h0, 1'b1);
        issue(0, 0, 3'b001, 32'd1,      32'h0,         32'h0, 1'b1);
        issue(0, 0, 3'b010, 32'(4*DW),  32'h0,         32'h0, 1'b1);
        issue(0, 0, 3'b011, 32'd0,      32'h0,         32'h0, 1'b1);
        issue(0, 1, 3'b100, 32'd0,      32'h0000_00AA, 32'h0, 1'b1);
        issue(0, 0, 3'b110, 32'd0,      32'h0,         32'h0, 1'b1);
        issue(0, 1, 3'b010, 32'(4*DW),  32'h5555_5555, 32'h0, 1'b1);
        issue(0, 1, 3'b001, 32'd5,      32'h0000_7777, 32'h0, 1'b1);
        issue(0, 0, 3'b010, 32'd0,      32'h0,         32'h8081_7F01, 1'b0);
        issue(0, 0, 3'b010, 32'd4,      32'h0,         32'hABCD_5500, 1'b0);
        idle(0);

        // ---- last word, then back-to-back store/load with valid held ----
        issue(0, 1, 3'b010, 32'(4*DW-4), 32'hCAFE_F00D, 32'h0,          1'b0);
        issue(0, 0, 3'b010, 32'(4*DW-4), 32'h0,         32'hCAFE_F00D, 1'b0);
        idle(0);
        issue(0, 1, 3'b010, 32'd12, 32'h1357_9BDF, 32'h0,          1'b0);
        issue(0, 0, 3'b010, 32'd12, 32'h0,         32'h1357_9BDF, 1'b0);
        idle(0);
        repeat (4) @(negedge clk);
        chk("mem0 dut0",  dut0.memory[0],  32'h8081_7F01);
        chk("mem1 dut0",  dut0.memory[1],  32'hABCD_5500);
        chk("mem3 dut0",  dut0.memory[3],  32'h1357_9BDF);
        chk("mem63 dut0", dut0.memory[63], 32'hCAFE_F00D);

        // ---- three wait states: exact response timing ----
        issue(1, 1, 3'b010, 32'd8, 32'h0BAD_F00D, 32'h0, 1'b0);
        idle(1);
        repeat (6) @(negedge clk);
        rv[1] = 1'b1; rw[1] = 1'b0; rf3[1] = 3'b010; ra[1] = 32'd8; rwd[1] = 32'd0;
        chk("ws3_ready_at_accept", {31'd0, rr[1]}, 32'd1);
        push(1, 32'h0BAD_F00D, 1'b0);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("ws3_ready cycle N+%0d", k), {31'd0, rr[1]}, (k <= 3) ? 32'd0 : 32'd1);
            chk($sformatf("ws3_valid cycle N+%0d", k), {31'd0, pv[1]}, (k == 4) ? 32'd1 : 32'd0);
            if (k == 3)
                rv[1] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // ---- two wait states: reset during WAIT aborts the store ----
        issue(2, 1, 3'b010, 32'd0, 32'h1111_2222, 32'h0, 1'b0);
        idle(2);
        repeat (5) @(negedge clk);
        rv[2] = 1'b1; rw[2] = 1'b1; rf3[2] = 3'b010; ra[2] = 32'd0; rwd[2] = 32'hDEAD_BEEF;
        chk("ws2_ready_at_accept", {31'd0, rr[2]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("ws2_in_wait_ready", {31'd0, rr[2]}, 32'd0);
        rst2_n = 1'b0;
        rv[2]  = 1'b0;
        #1;
        chk("ws2_rst_ready", {31'd0, rr[2]}, 32'd0);
        chk("ws2_rst_valid", {31'd0, pv[2]}, 32'd0);
        repeat (3) @(negedge clk);
        rst2_n = 1'b1;
        chk("ws2_mem_after_abort", dut2.memory[0], 32'h1111_2222);
        @(negedge clk);
        chk("ws2_ready_after_release", {31'd0, rr[2]}, 32'd1);
        repeat (4) @(negedge clk);
        chk("ws2_mem_later", dut2.memory[0], 32'h1111_2222);
        issue(2, 0, 3'b010, 32'd0, 32'h0, 32'h1111_2222, 1'b0);
        idle(2);
        repeat (8) @(negedge clk);

        chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
